// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and constants for the junction light sequencer
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    PED_WALK  = 3'd6
  } light_state_e;

  typedef enum logic {
    NS = 1'b0,
    EW = 1'b1
  } road_e;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  // Longest dwell among all phases, used to size the dwell counter.
  function automatic int max_ticks(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Counter width for a given longest dwell, never below one bit.
  function automatic int cnt_width(input int longest);
    int w;
    w = $clog2(longest);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/traffic_light_fsm_if.sv
// rtl/traffic_light_fsm_if.sv - ticker/button inputs and light outputs of the sequencer
interface traffic_light_fsm_if;
  logic       timer_clk;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  modport master (
    output timer_clk, ped_req,
    input  ns_light, ew_light, walk, ped_ack, phase
  );

  modport slave (
    input  timer_clk, ped_req,
    output ns_light, ew_light, walk, ped_ack, phase
  );
endinterface

// File: rtl/tick_edge_detect.sv
// rtl/tick_edge_detect.sv - turns every level change of timer_clk into a one-cycle tick
module tick_edge_detect (
  input  logic clk,
  input  logic rstb,
  input  logic timer_clk_i,
  output logic tick_o
);

  logic tc_q;

  // Remember the previous timer_clk level; reset level matches the ticker's.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= timer_clk_i;
    end
  end

  assign tick_o = timer_clk_i ^ tc_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - two-road junction light sequencer with pedestrian walk phase
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 4
) (
  input logic               clk,
  input logic               rstb,
  traffic_light_fsm_if.slave bus
);

  localparam int MAX_TICKS = max_ticks(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS, WALK_TICKS);
  localparam int CNT_W     = cnt_width(MAX_TICKS);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t GREEN_LAST  = cnt_t'(GREEN_TICKS - 1);
  localparam cnt_t YELLOW_LAST = cnt_t'(YELLOW_TICKS - 1);
  localparam cnt_t ALLRED_LAST = cnt_t'(ALLRED_TICKS - 1);
  localparam cnt_t WALK_LAST   = cnt_t'(WALK_TICKS - 1);

  light_state_e state_q, state_d;
  road_e        next_road_q, next_road_d;
  cnt_t         tick_cnt_q, tick_cnt_d;
  logic         ped_pending_q, ped_pending_d;
  logic         ped_ack_q, ped_ack_d;
  logic         tick;
  cnt_t         dwell_last;

  tick_edge_detect u_tick (
    .clk         (clk),
    .rstb        (rstb),
    .timer_clk_i (bus.timer_clk),
    .tick_o      (tick)
  );

  // Last counter value of the phase currently being shown.
  always_comb begin
    dwell_last = ALLRED_LAST;
    case (state_q)
      NS_GREEN, EW_GREEN:   dwell_last = GREEN_LAST;
      NS_YELLOW, EW_YELLOW: dwell_last = YELLOW_LAST;
      PED_WALK:             dwell_last = WALK_LAST;
      default:              dwell_last = ALLRED_LAST;
    endcase
  end

  // Phase sequencing, dwell counting and pedestrian request latching.
  always_comb begin
    state_d       = state_q;
    next_road_d   = next_road_q;
    tick_cnt_d    = tick_cnt_q;
    ped_pending_d = ped_pending_q | bus.ped_req;
    ped_ack_d     = 1'b0;

    if (tick) begin
      if (tick_cnt_q == dwell_last) begin
        tick_cnt_d = '0;
        case (state_q)
          NS_GREEN:  state_d = NS_YELLOW;
          NS_YELLOW: state_d = ALLRED_A;
          ALLRED_A: begin
            next_road_d = EW;
            state_d     = ped_pending_q ? PED_WALK : EW_GREEN;
          end
          EW_GREEN:  state_d = EW_YELLOW;
          EW_YELLOW: state_d = ALLRED_B;
          ALLRED_B: begin
            next_road_d = NS;
            state_d     = ped_pending_q ? PED_WALK : NS_GREEN;
          end
          PED_WALK:  state_d = (next_road_q == NS) ? NS_GREEN : EW_GREEN;
          default:   state_d = ALLRED_B;
        endcase
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end

    // Entering the walk serves the request; a press in that same cycle is absorbed.
    if ((state_d == PED_WALK) && (state_q != PED_WALK)) begin
      ped_pending_d = 1'b0;
      ped_ack_d     = 1'b1;
    end
  end

  // State registers; reset parks the junction in all-red ahead of NS green.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= ALLRED_B;
      next_road_q   <= NS;
      tick_cnt_q    <= '0;
      ped_pending_q <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_road_q   <= next_road_d;
      tick_cnt_q    <= tick_cnt_d;
      ped_pending_q <= ped_pending_d;
      ped_ack_q     <= ped_ack_d;
    end
  end

  // Moore decode of the lights from the state register.
  always_comb begin
    bus.ns_light = LIGHT_RED;
    bus.ew_light = LIGHT_RED;
    bus.walk     = 1'b0;
    case (state_q)
      NS_GREEN:  bus.ns_light = LIGHT_GREEN;
      NS_YELLOW: bus.ns_light = LIGHT_YELLOW;
      EW_GREEN:  bus.ew_light = LIGHT_GREEN;
      EW_YELLOW: bus.ew_light = LIGHT_YELLOW;
      PED_WALK:  bus.walk     = 1'b1;
      default:   bus.walk     = 1'b0;
    endcase
  end

  assign bus.ped_ack = ped_ack_q;
  assign bus.phase   = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb/tb_traffic_light_fsm.sv - scoreboard bench for the junction light sequencer
module tb_traffic_light_fsm;
  import traffic_pkg::*;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  logic tc   = 1'b0;
  logic preq = 1'b0;
  int   cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  traffic_light_fsm_if if0 ();
  traffic_light_fsm_if if1 ();

  assign if0.timer_clk = tc;
  assign if0.ped_req   = preq;
  assign if1.timer_clk = tc;
  assign if1.ped_req   = preq;

  traffic_light_fsm #(
    .GREEN_TICKS(8), .YELLOW_TICKS(3), .ALLRED_TICKS(1), .WALK_TICKS(4)
  ) u_dut0 (.clk(clk), .rstb(rstb), .bus(if0.slave));

  traffic_light_fsm #(
    .GREEN_TICKS(1), .YELLOW_TICKS(1), .ALLRED_TICKS(1), .WALK_TICKS(1)
  ) u_dut1 (.clk(clk), .rstb(rstb), .bus(if1.slave));

  typedef struct {
    int          cyc;
    logic [10:0] v0;
    logic [10:0] v1;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: position on the six-phase ring plus a "walk inserted" flag.
  int m_pos  [2];
  bit m_walk [2];
  int m_left [2];
  bit m_pend [2];
  bit m_ack  [2];
  bit m_lasttc;

  function automatic light_state_e ring_ph(input int p);
    case (p)
      0: return NS_GREEN;
      1: return NS_YELLOW;
      2: return ALLRED_A;
      3: return EW_GREEN;
      4: return EW_YELLOW;
      default: return ALLRED_B;
    endcase
  endfunction

  function automatic int dur_of(input int k, input bit walk, input int p);
    if (k == 1) return 1;
    if (walk) return 4;
    if (p == 0 || p == 3) return 8;
    if (p == 1 || p == 4) return 3;
    return 1;
  endfunction

  function automatic logic [10:0] exp_vec(input int k);
    light_state_e ph;
    logic [2:0]   ns;
    logic [2:0]   ew;
    ns = LIGHT_RED;
    ew = LIGHT_RED;
    ph = m_walk[k] ? PED_WALK : ring_ph(m_pos[k]);
    if (!m_walk[k]) begin
      if (m_pos[k] == 0) ns = LIGHT_GREEN;
      if (m_pos[k] == 1) ns = LIGHT_YELLOW;
      if (m_pos[k] == 3) ew = LIGHT_GREEN;
      if (m_pos[k] == 4) ew = LIGHT_YELLOW;
    end
    return {ph, ns, ew, m_walk[k], m_ack[k]};
  endfunction

  function automatic logic [10:0] act_vec(input int k);
    if (k == 1) return {if1.phase, if1.ns_light, if1.ew_light, if1.walk, if1.ped_ack};
    return {if0.phase, if0.ns_light, if0.ew_light, if0.walk, if0.ped_ack};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pos[k]  = 5;
      m_walk[k] = 1'b0;
      m_left[k] = dur_of(k, 1'b0, 5);
      m_pend[k] = 1'b0;
      m_ack[k]  = 1'b0;
    end
    m_lasttc = 1'b0;
  endtask

  // Advance the model by one clock with the inputs the DUT samples at the next edge.
  task automatic model_step(input bit t, input bit r, input bit rb);
    bit tick;
    bit entering;
    if (!rb) begin
      model_reset();
      return;
    end
    tick = (t != m_lasttc);
    for (int k = 0; k < 2; k++) begin
      m_ack[k] = 1'b0;
      entering = 1'b0;
      if (tick) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          if (m_walk[k]) begin
            m_walk[k] = 1'b0;
            m_pos[k]  = (m_pos[k] + 1) % 6;
          end else if ((m_pos[k] == 2 || m_pos[k] == 5) && m_pend[k]) begin
            m_walk[k] = 1'b1;
            entering  = 1'b1;
            m_ack[k]  = 1'b1;
            m_pend[k] = 1'b0;
          end else begin
            m_pos[k] = (m_pos[k] + 1) % 6;
          end
          m_left[k] = dur_of(k, m_walk[k], m_pos[k]);
        end
      end
      if (!entering && r) m_pend[k] = 1'b1;
    end
    m_lasttc = t;
  endtask

  task automatic check_vec(input string name, input logic [10:0] a, input logic [10:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, a, e);
    end
  endtask

  task automatic step(input logic t, input logic r, input logic rb);
    exp_t e;
    @(posedge clk);
    #1;
    tc   = t;
    preq = r;
    if (!rb && rstb) begin
      rstb = 1'b0;
      #1;
      check_vec("async_reset_dut0", act_vec(0), {ALLRED_B, LIGHT_RED, LIGHT_RED, 1'b0, 1'b0});
      check_vec("async_reset_dut1", act_vec(1), {ALLRED_B, LIGHT_RED, LIGHT_RED, 1'b0, 1'b0});
      model_reset();
      sbq.delete();
      e.cyc = cyc;
      e.v0  = exp_vec(0);
      e.v1  = exp_vec(1);
      sbq.push_back(e);
    end else begin
      rstb = rb;
    end
    model_step(t, r, rb);
    e.cyc = cyc + 1;
    e.v0  = exp_vec(0);
    e.v1  = exp_vec(1);
    sbq.push_back(e);
  endtask

  task automatic ticks(input int n, input logic r);
    for (int i = 0; i < n; i++) begin
      step(~tc, r, 1'b1);
      repeat ($urandom_range(0, 2)) step(tc, r, 1'b1);
    end
  endtask

  task automatic wait_pos(input int p, input string name);
    int guard;
    guard = 0;
    while (!(m_pos[0] == p && !m_walk[0]) && guard < 60) begin
      ticks(1, 1'b0);
      guard++;
    end
    n_checks++;
    if (guard >= 60) begin
      n_fail++;
      $display("FAIL %s timeout actual_pos=%0d required_pos=%0d", name, m_pos[0], p);
    end
  endtask

  // Monitor: pop the expectation for this cycle and compare, plus invariants.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      while (sbq.size() > 0 && sbq[0].cyc < cyc) void'(sbq.pop_front());
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        e = sbq.pop_front();
        check_vec("outputs_dut0", act_vec(0), e.v0);
        check_vec("outputs_dut1", act_vec(1), e.v1);
      end
      n_checks++;
      if (if0.ns_light != LIGHT_RED && if0.ew_light != LIGHT_RED) begin
        n_fail++;
        $display("FAIL safety_dut0 cyc=%0d ns=%b ew=%b required one red", cyc, if0.ns_light, if0.ew_light);
      end
      n_checks++;
      if (if1.ns_light != LIGHT_RED && if1.ew_light != LIGHT_RED) begin
        n_fail++;
        $display("FAIL safety_dut1 cyc=%0d ns=%b ew=%b required one red", cyc, if1.ns_light, if1.ew_light);
      end
      n_checks++;
      if (u_dut1.tick_cnt_q !== 1'b0) begin
        n_fail++;
        $display("FAIL cnt_zero_dut1 cyc=%0d actual=%b required=0", cyc, u_dut1.tick_cnt_q);
      end
    end
  end

  initial begin
    int guard;
    model_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Plain cycle with no requests, 25 ticks.
    ticks(25, 1'b0);

    // Single-cycle press during NS green.
    wait_pos(0, "wait_ns_green");
    step(tc, 1'b1, 1'b1);
    step(tc, 1'b0, 1'b1);
    ticks(20, 1'b0);

    // Press held across walk entry, then kept a little beyond it.
    guard = 0;
    while (!m_ack[0] && guard < 200) begin
      step(~tc, 1'b1, 1'b1);
      guard++;
    end
    n_checks++;
    if (!m_ack[0]) begin
      n_fail++;
      $display("FAIL held_req_walk timeout actual_ack=0 required_ack=1");
    end
    step(tc, 1'b1, 1'b1);
    step(tc, 1'b1, 1'b1);
    ticks(40, 1'b0);

    // timer_clk static: nothing may move.
    repeat (100) step(tc, 1'b0, 1'b1);

    // Reset mid EW yellow with a request pending.
    wait_pos(3, "wait_ew_green");
    step(tc, 1'b1, 1'b1);
    wait_pos(4, "wait_ew_yellow");
    step(tc, 1'b0, 1'b1);
    step(tc, 1'b0, 1'b0);
    step(tc, 1'b0, 1'b0);
    step(tc, 1'b0, 1'b1);
    ticks(30, 1'b0);

    // Randomized traffic and presses.
    for (int i = 0; i < 1500; i++) begin
      logic t;
      t = tc;
      if ($urandom_range(0, 1) == 1) t = ~tc;
      step(t, ($urandom_range(0, 15) == 0), 1'b1);
    end

    repeat (3) step(tc, 1'b0, 1'b1);
    @(posedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
